// File: rtl/mlaccel_banked_memory.sv
// rtl/mlaccel_banked_memory.sv - banked multi-port byte-enabled word memory with per-bank round-robin arbitration
module mlaccel_banked_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int NUM_BANKS  = 4,
  parameter int NUM_PORTS  = 2
) (
  input  logic                                clock,
  input  logic                                resetn,
  input  logic [NUM_PORTS-1:0]                req_valid,
  output logic [NUM_PORTS-1:0]                req_ready,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] req_wen,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_wdata,
  output logic [NUM_PORTS-1:0]                rsp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]     rsp_rdata
);

  localparam int NB         = DATA_WIDTH / 8;
  localparam int BANK_SHIFT = $clog2(NUM_BANKS);
  localparam int BW         = (NUM_BANKS > 1) ? BANK_SHIFT : 1;
  localparam int PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int LW         = ADDR_WIDTH - BANK_SHIFT;
  localparam int BANK_DEPTH = 1 << LW;

  // Per-port views of the flattened request buses
  logic [ADDR_WIDTH-1:0] p_addr  [NUM_PORTS];
  logic [NB-1:0]         p_wen   [NUM_PORTS];
  logic [DATA_WIDTH-1:0] p_wdata [NUM_PORTS];
  logic [BW-1:0]         p_bank  [NUM_PORTS];
  logic [LW-1:0]         p_idx   [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign p_addr[p]  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign p_wen[p]   = req_wen[p*NB +: NB];
    assign p_wdata[p] = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
    // Low address bits pick the bank (always 0 with a single bank)
    assign p_bank[p]  = BW'(p_addr[p] & ADDR_WIDTH'(NUM_BANKS - 1));
    assign p_idx[p]   = LW'(p_addr[p] >> BANK_SHIFT);
  end

  // Arbitration state and per-bank grant
  logic [PW-1:0]        rr   [NUM_BANKS];
  logic [NUM_BANKS-1:0] gany;
  logic [PW-1:0]        gsel [NUM_BANKS];

  // Per bank, grant the first requesting port at or after the round-robin pointer
  always_comb begin
    int q;
    q = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      gany[b] = 1'b0;
      gsel[b] = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        q = int'(rr[b]) + k;
        if (q >= NUM_PORTS) q = q - NUM_PORTS;
        if (!gany[b] && resetn && req_valid[q] && (p_bank[q] == BW'(b))) begin
          gany[b] = 1'b1;
          gsel[b] = PW'(q);
        end
      end
    end
  end

  // A port is ready exactly when the bank it addresses picked it
  always_comb begin
    req_ready = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (gany[b] && (gsel[b] == PW'(p))) req_ready[p] = 1'b1;
      end
    end
  end

  // Advance each bank's pointer past the port it just granted
  always_ff @(posedge clock) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!resetn) begin
        rr[b] <= '0;
      end else if (gany[b]) begin
        rr[b] <= (int'(gsel[b]) == NUM_PORTS - 1) ? '0 : gsel[b] + 1'b1;
      end
    end
  end

  // Winner's address and write payload routed to each bank
  logic [LW-1:0]         bank_idx   [NUM_BANKS];
  logic [NB-1:0]         bank_wen   [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_wdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

  // Steer the granted port's request onto its bank
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_idx[b]   = p_idx[gsel[b]];
      bank_wen[b]   = p_wen[gsel[b]];
      bank_wdata[b] = p_wdata[gsel[b]];
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Single-port bank: the read sees the old word, enabled byte lanes are then updated
    always_ff @(posedge clock) begin
      if (gany[b]) begin
        rdata_q <= mem[bank_idx[b]];
        for (int i = 0; i < NB; i++) begin
          if (bank_wen[b][i]) mem[bank_idx[b]][i*8 +: 8] <= bank_wdata[b][i*8 +: 8];
        end
      end
    end

    assign bank_rdata[b] = rdata_q;
  end

  // Response tracking
  logic [NUM_PORTS-1:0]  rd_pend;
  logic [BW-1:0]         rd_bank [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rd_hold [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rsp_word [NUM_PORTS];

  // Remember which accepted requests were reads and which bank will return them
  always_ff @(posedge clock) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!resetn) begin
        rd_pend[p] <= 1'b0;
      end else begin
        rd_pend[p] <= req_ready[p] && (p_wen[p] == '0);
      end
      rd_bank[p] <= p_bank[p];
    end
  end

  // Present bank data on the response cycle; a reset arriving that cycle drops it
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rsp_valid[p] = rd_pend[p] & resetn;
      rsp_word[p]  = rsp_valid[p] ? bank_rdata[rd_bank[p]] : rd_hold[p];
      rsp_rdata[p*DATA_WIDTH +: DATA_WIDTH] = rsp_word[p];
    end
  end

  // Keep the last delivered word on the output between responses
  always_ff @(posedge clock) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!resetn) begin
        rd_hold[p] <= '0;
      end else if (rsp_valid[p]) begin
        rd_hold[p] <= rsp_word[p];
      end
    end
  end

endmodule

// File: tb/tb_mlaccel_banked_memory.sv
// tb/tb_mlaccel_banked_memory.sv - scoreboard testbench for mlaccel_banked_memory
module tb_mlaccel_banked_memory;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [33:0] req_addr = '0;
  logic [7:0]  req_wen = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  rsp_valid;
  logic [63:0] rsp_rdata;

  mlaccel_banked_memory dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wen   (req_wen),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q [2][$];
  logic [31:0] ref_mem [int];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pop expected read data whenever a port presents a response
  always @(negedge clock) begin
    exp_t e;
    for (int p = 0; p < 2; p++) begin
      if (rsp_valid[p] === 1'b1) begin
        if (exp_q[p].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rsp_unexpected_p%0d: got rdata %h with nothing pending", p, rsp_rdata[p*32 +: 32]);
        end else begin
          e = exp_q[p].pop_front();
          check($sformatf("rsp_data_p%0d", p), 64'(rsp_rdata[p*32 +: 32]), 64'(e.data));
          check($sformatf("rsp_cycle_p%0d", p), 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  // Record an accepted transfer in the reference memory / scoreboard
  task automatic accept(input int p, input logic [16:0] a, input logic [3:0] w, input logic [31:0] d);
    exp_t e;
    logic [31:0] m;
    if (w == 4'h0) begin
      e.data = ref_mem[int'(a)];
      e.due  = cyc + 1;
      exp_q[p].push_back(e);
    end else begin
      m = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
      for (int i = 0; i < 4; i++) if (w[i]) m[i*8 +: 8] = d[i*8 +: 8];
      ref_mem[int'(a)] = m;
    end
  endtask

  // One cycle of stimulus on both ports; returns req_ready sampled mid-cycle
  task automatic step(input logic [1:0] v,
                      input logic [16:0] a0, input logic [3:0] w0, input logic [31:0] d0,
                      input logic [16:0] a1, input logic [3:0] w1, input logic [31:0] d1,
                      output logic [1:0] r);
    req_valid = v;
    req_addr  = {a1, a0};
    req_wen   = {w1, w0};
    req_wdata = {d1, d0};
    @(negedge clock);
    r = req_ready;
    if (v[0] && r[0]) accept(0, a0, w0, d0);
    if (v[1] && r[1]) accept(1, a1, w1, d1);
    @(posedge clock);
    #1;
    req_valid = '0;
  endtask

  task automatic idle(input int n);
    logic [1:0] r;
    for (int i = 0; i < n; i++) step(2'b00, 17'd0, 4'h0, 32'h0, 17'd0, 4'h0, 32'h0, r);
  endtask

  // Single-port transfer, retried while the bank is busy, bounded
  task automatic xfer(input int p, input logic [16:0] a, input logic [3:0] w, input logic [31:0] d);
    logic [1:0] r;
    int n;
    n = 0;
    r = '0;
    while (!r[p] && n < 20) begin
      if (p == 0) step(2'b01, a, w, d, 17'd0, 4'h0, 32'h0, r);
      else        step(2'b10, 17'd0, 4'h0, 32'h0, a, w, d, r);
      n++;
    end
    if (!r[p]) begin
      vectors++;
      miscompares++;
      $display("FAIL xfer_timeout_p%0d: addr %0d not accepted within %0d cycles", p, a, n);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got time %0t expected end earlier", $time);
    $fatal(1);
  end

  initial begin
    logic [1:0] r;
    logic [1:0] pend;
    int n;

    // Reset state, with requests pending on both ports
    req_valid = 2'b11;
    req_addr  = {17'd1, 17'd0};
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_req_ready", 64'(req_ready), 64'h0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    check("reset_rsp_rdata", rsp_rdata, 64'h0);
    @(posedge clock);
    #1;
    req_valid = '0;
    resetn = 1'b1;

    // 1: fill 0..999 with data=addr, read back on port 0
    for (int a = 0; a < 1000; a++) xfer(0, 17'(a), 4'hF, 32'(a));
    for (int a = 0; a < 1000; a++) xfer(0, 17'(a), 4'h0, 32'h0);

    // 2: byte-lane merge -> AA22CC44
    xfer(0, 17'd5, 4'hF, 32'hAABBCCDD);
    xfer(0, 17'd5, 4'b0101, 32'h11223344);
    xfer(0, 17'd5, 4'h0, 32'h0);
    xfer(1, 17'd5, 4'h0, 32'h0);

    // 3: different banks granted together
    step(2'b11, 17'd4, 4'h0, 32'h0, 17'd5, 4'h0, 32'h0, r);
    check("parallel_ready", 64'(r), 64'h3);
    idle(2);

    // Reset to bring all round-robin pointers to 0
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;

    // 4: both ports on bank 2 -> grants 0,1,0,1,0,1
    for (int i = 0; i < 6; i++) begin
      step(2'b11, 17'd2, 4'h0, 32'h0, 17'd6, 4'h0, 32'h0, r);
      check($sformatf("conflict_grant_%0d", i), 64'(r), (i % 2 == 0) ? 64'h1 : 64'h2);
    end
    idle(2);

    // 5: write then read on next cycle, then same-cycle same-bank serialisation
    xfer(0, 17'd8, 4'hF, 32'd3);
    step(2'b01, 17'd8, 4'hF, 32'd7, 17'd0, 4'h0, 32'h0, r);
    check("rbw_write_ready", 64'(r), 64'h1);
    step(2'b10, 17'd0, 4'h0, 32'h0, 17'd8, 4'h0, 32'h0, r);
    check("rbw_read_ready", 64'(r), 64'h2);
    pend = 2'b11;
    step(pend, 17'd8, 4'hF, 32'd9, 17'd8, 4'h0, 32'h0, r);
    check("serial_first_grant", 64'(r), 64'h1);
    pend = pend & ~r;
    n = 0;
    while (pend != 2'b00 && n < 10) begin
      step(pend, 17'd8, 4'hF, 32'd9, 17'd8, 4'h0, 32'h0, r);
      pend = pend & ~r;
      n++;
    end
    check("serial_all_accepted", 64'(pend), 64'h0);
    idle(2);

    // 6: read accepted, reset the next cycle -> no response, memory intact
    step(2'b01, 17'd10, 4'h0, 32'h0, 17'd0, 4'h0, 32'h0, r);
    check("rst_read_ready", 64'(r), 64'h1);
    resetn = 1'b0;
    void'(exp_q[0].pop_back());
    req_valid = 2'b11;
    req_addr  = {17'd1, 17'd0};
    req_wen   = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("rst_rsp_valid_%0d", k), 64'(rsp_valid), 64'h0);
      check($sformatf("rst_req_ready_%0d", k), 64'(req_ready), 64'h0);
      @(posedge clock);
      #1;
    end
    resetn = 1'b1;
    req_valid = '0;
    @(negedge clock);
    check("post_reset_rsp_rdata", rsp_rdata, 64'h0);
    @(posedge clock);
    #1;
    xfer(0, 17'd10, 4'h0, 32'h0);
    xfer(0, 17'd5, 4'h0, 32'h0);
    xfer(0, 17'd8, 4'h0, 32'h0);
    xfer(0, 17'd999, 4'h0, 32'h0);
    xfer(1, 17'd6, 4'h0, 32'h0);
    idle(3);

    check("pending_p0_empty", 64'(exp_q[0].size()), 64'h0);
    check("pending_p1_empty", 64'(exp_q[1].size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
